instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the byte-addressed, little-endian, combinational-read instruction memory.
- Owns the 64-bit PC and drives the memory address.
- Captures the returned 32-bit instruction with its PC into an IF/ID output register, using a valid/ready handshake toward decode.
- Handles branch/jump redirects, fetch enable, and alignment/range faults, and counts delivered instructions.

Parameters:
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.
- MEM_BYTES, 16, instruction memory size in bytes; legal fetch addresses are 0 .. MEM_BYTES-4.
- COUNT_W, 32, width of the delivered-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- fetch_en  input  1  permits new fetches when 1
- branch_taken  input  1  redirect request, single-cycle pulse
- branch_target  input  64  redirect byte address
- inst_addr  output  64  address to instruction memory; always equals the PC register
- instr_in  input  32  instruction word from memory, same cycle as inst_addr
- if_valid  output  1  IF/ID register holds an instruction
- id_ready  input  1  decode accepts this cycle
- if_pc  output  64  PC of the held instruction
- if_instruction  output  32  held instruction word
- fault  output  1  sticky fault flag
- fault_cause  output  2  01 = misaligned redirect, 10 = fetch out of range, 00 = none
- fetch_count  output  COUNT_W  number of completed handshakes (if_valid && id_ready)

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, including mid-operation):
  - PC=RESET_PC, if_valid=0, if_pc=0, if_instruction=0, fault=0, fault_cause=00, fetch_count=0, state=RUN.
  - Any in-flight instruction is discarded.
- States: RUN, FAULT. FAULT is left only by reset.
- Definitions: accept = if_valid && id_ready. slot_free = !if_valid || accept.
- RUN, priority high to low, evaluated at each rising edge:
  1. branch_taken=1:
     - if_valid<=0; the instruction at the current PC is dropped.
     - If branch_target[1:0]!=0 or branch_target>MEM_BYTES-4: go to FAULT. fault<=1. fault_cause<=01 if misaligned, else 10. PC unchanged.
     - Otherwise PC<=branch_target.
     - fetch_en and id_ready do not block a redirect.
  2. fetch_en=1 && slot_free:
     - If PC>MEM_BYTES-4: go to FAULT, fault_cause<=10, if_valid<=0.
     - Otherwise: if_pc<=PC, if_instruction<=instr_in, if_valid<=1, PC<=PC+4.
     - Latency: instruction at PC is visible on the outputs one cycle after PC is driven.
     - Sustained throughput is 1 instruction/cycle while id_ready=1.
  3. slot_free but fetch_en=0: if_valid<=0 if accepted; PC holds.
  4. if_valid && !id_ready (stall):
     - if_pc and if_instruction hold stable; PC holds.
     - if_valid must not drop except on redirect, fault or reset.
- fetch_count increments by 1 on every accept, including an accept in the same cycle as a redirect or fault entry. It wraps modulo 2^COUNT_W.
- FAULT: if_valid=0, PC frozen, fetch_count frozen; branch_taken, fetch_en and id_ready are ignored.
- PC arithmetic is 64-bit unsigned, +4 per fetch. Out-of-range fetches fault; the PC never wraps.
- inst_addr is combinational from the PC register only, with no input-to-output path.

Test Plan:

The memory model holds words 0x0F053483 @0, 0x009A84B3 @4, 0x00148493 @8, 0x0E953823 @12. Default MEM_BYTES=16 and RESET_PC=0.

1. Streaming: release reset, fetch_en=1, id_ready=1 → cycles 1-4 deliver (if_pc, if_instruction) = (0, 0x0F053483), (4, 0x009A84B3), (8, 0x00148493), (12, 0x0E953823). Next fetch at PC=16 → fault=1, fault_cause=10, if_valid=0, fetch_count=4.
2. Stall: id_ready=0 for 3 cycles while holding PC 4 → if_pc=4 and if_instruction=0x009A84B3 stable, inst_addr=8 constant. id_ready=1 → next cycle if_pc=8.
3. Redirect: branch_taken=1 with branch_target=12 while if_pc=0 is being accepted → fetch_count increments, if_valid=0 next cycle, then (12, 0x0E953823).
4. Misaligned redirect: branch_target=6 → fault=1, fault_cause=01, if_valid=0; further branch_taken and fetch_en have no effect.
5. Async reset mid-stream: drop reset between clock edges while if_valid=1 → outputs clear immediately. After release, the first delivery is (0, 0x0F053483) and fetch_count=0.
6. fetch_en=0 with the slot empty → if_valid stays 0, inst_addr holds. Re-enable → fetch resumes from the held PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the combinational-read
// instruction memory, and holds the fetched word in an IF/ID register
// handed to decode with a valid/ready handshake. Bad redirects and
// out-of-range fetches park the unit in a sticky FAULT state.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          MEM_BYTES = 16,
  parameter int          COUNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               branch_taken,
  input  logic [63:0]        branch_target,
  output logic [63:0]        inst_addr,
  input  logic [31:0]        instr_in,
  output logic               if_valid,
  input  logic               id_ready,
  output logic [63:0]        if_pc,
  output logic [31:0]        if_instruction,
  output logic               fault,
  output logic [1:0]         fault_cause,
  output logic [COUNT_W-1:0] fetch_count
);

  // Highest byte address at which a whole 32-bit word still fits.
  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 4);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  state_t               r_state;
  logic [63:0]          r_pc;
  logic                 r_valid;
  logic [63:0]          r_if_pc;
  logic [31:0]          r_if_instr;
  logic                 r_fault;
  logic [1:0]           r_cause;
  logic [COUNT_W-1:0]   r_count;

  logic w_accept;
  logic w_slot_free;
  logic w_br_misaligned;
  logic w_br_out_of_range;
  logic w_pc_out_of_range;

  assign w_accept          = r_valid && id_ready;
  assign w_slot_free       = !r_valid || w_accept;
  assign w_br_misaligned   = (branch_target[1:0] != 2'b00);
  assign w_br_out_of_range = (branch_target > LAST_PC);
  assign w_pc_out_of_range = (r_pc > LAST_PC);

  // Memory address comes straight from the PC register, never from inputs.
  assign inst_addr      = r_pc;
  assign if_valid       = r_valid;
  assign if_pc          = r_if_pc;
  assign if_instruction = r_if_instr;
  assign fault          = r_fault;
  assign fault_cause    = r_cause;
  assign fetch_count    = r_count;

  // Fetch FSM: redirect beats fetch, fetch beats drain; FAULT only exits on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_if_pc    <= 64'd0;
      r_if_instr <= 32'd0;
      r_fault    <= 1'b0;
      r_cause    <= 2'b00;
    end else begin
      case (r_state)
        S_RUN: begin
          if (branch_taken) begin
            // The word currently at the PC belongs to the wrong path.
            r_valid <= 1'b0;
            if (w_br_misaligned || w_br_out_of_range) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
              r_cause <= w_br_misaligned ? CAUSE_MISALIGN : CAUSE_RANGE;
            end else begin
              r_pc <= branch_target;
            end
          end else if (fetch_en && w_slot_free) begin
            if (w_pc_out_of_range) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
              r_cause <= CAUSE_RANGE;
              r_valid <= 1'b0;
            end else begin
              r_if_pc    <= r_pc;
              r_if_instr <= instr_in;
              r_valid    <= 1'b1;
              r_pc       <= r_pc + 64'd4;
            end
          end else if (w_slot_free) begin
            // Either empty already or the held word just left; nothing replaces it.
            r_valid <= 1'b0;
          end
        end
        S_FAULT: begin
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= S_FAULT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Delivered-instruction counter; counts every handshake, wrapping naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand-written
// corner sequences, and a randomized run against a behavioural model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] inst_addr;
  logic [31:0] instr_in;
  logic        if_valid;
  logic        id_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instruction;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fetch_count;

  int checks;
  int failures;

  instruction_fetch_unit #(
    .RESET_PC (64'd0),
    .MEM_BYTES(16),
    .COUNT_W  (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .inst_addr     (inst_addr),
    .instr_in      (instr_in),
    .if_valid      (if_valid),
    .id_ready      (id_ready),
    .if_pc         (if_pc),
    .if_instruction(if_instruction),
    .fault         (fault),
    .fault_cause   (fault_cause),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian word memory of 16 bytes.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'd0)  return 32'h0F053483;
    if (a == 64'd4)  return 32'h009A84B3;
    if (a == 64'd8)  return 32'h00148493;
    if (a == 64'd12) return 32'h0E953823;
    return 32'h0;
  endfunction

  always_comb instr_in = mem_word(inst_addr);

  // ---------------- behavioural reference model ----------------
  logic [63:0] m_pc;
  logic        m_valid;
  logic [63:0] m_ipc;
  logic [31:0] m_iins;
  logic        m_fault;
  logic [1:0]  m_cause;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_pc = 64'd0; m_valid = 1'b0; m_ipc = 64'd0; m_iins = 32'd0;
    m_fault = 1'b0; m_cause = 2'b00; m_cnt = 32'd0;
  endtask

  task automatic model_step();
    bit take;
    bit room;
    take = m_valid && id_ready;
    room = !m_valid || take;
    if (m_fault) return;
    if (take) m_cnt = m_cnt + 32'd1;
    if (branch_taken) begin
      m_valid = 1'b0;
      if (branch_target % 4 != 0) begin
        m_fault = 1'b1; m_cause = 2'd1;
      end else if (branch_target > 64'd12) begin
        m_fault = 1'b1; m_cause = 2'd2;
      end else begin
        m_pc = branch_target;
      end
    end else if (fetch_en && room) begin
      if (m_pc > 64'd12) begin
        m_fault = 1'b1; m_cause = 2'd2; m_valid = 1'b0;
      end else begin
        m_ipc = m_pc; m_iins = mem_word(m_pc); m_valid = 1'b1; m_pc = m_pc + 64'd4;
      end
    end else if (room) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic fe, input logic br, input logic [63:0] tgt, input logic rdy);
    fetch_en = fe; branch_taken = br; branch_target = tgt; id_ready = rdy;
  endtask

  // Called one time unit after a rising edge (or at time 0); releases before the next edge.
  task automatic do_reset();
    set_in(1'b0, 1'b0, 64'd0, 1'b0);
    reset = 1'b0;
    #3;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".inst_addr"}, inst_addr, m_pc);
    chk({tag, ".if_valid"}, {63'd0, if_valid}, {63'd0, m_valid});
    if (m_valid) begin
      chk({tag, ".if_pc"}, if_pc, m_ipc);
      chk({tag, ".if_instruction"}, {32'd0, if_instruction}, {32'd0, m_iins});
    end
    chk({tag, ".fault"}, {63'd0, fault}, {63'd0, m_fault});
    chk({tag, ".fault_cause"}, {62'd0, fault_cause}, {62'd0, m_cause});
    chk({tag, ".fetch_count"}, {32'd0, fetch_count}, {32'd0, m_cnt});
  endtask

  typedef struct {
    logic        fe;
    logic        br;
    logic        rdy;
    logic [63:0] tgt;
    logic        exp_valid;
    logic [63:0] exp_pc;
    logic [31:0] exp_ins;
    logic        exp_fault;
    logic [1:0]  exp_cause;
    logic [31:0] exp_cnt;
    logic [63:0] exp_addr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    checks = 0;
    failures = 0;

    // Streaming through the whole memory, then running off its end.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 64'd0, 1'b1, 64'd0,  32'h0F053483, 1'b0, 2'b00, 32'd0, 64'd4};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 64'd0, 1'b1, 64'd4,  32'h009A84B3, 1'b0, 2'b00, 32'd1, 64'd8};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 64'd0, 1'b1, 64'd8,  32'h00148493, 1'b0, 2'b00, 32'd2, 64'd12};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 64'd0, 1'b1, 64'd12, 32'h0E953823, 1'b0, 2'b00, 32'd3, 64'd16};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 64'd0, 1'b0, 64'd12, 32'h0E953823, 1'b1, 2'b10, 32'd4, 64'd16};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 64'd0, 1'b0, 64'd12, 32'h0E953823, 1'b1, 2'b10, 32'd4, 64'd16};

    do_reset();
    chk("reset.inst_addr", inst_addr, 64'd0);
    chk("reset.if_valid", {63'd0, if_valid}, 64'd0);
    chk("reset.if_pc", if_pc, 64'd0);
    chk("reset.fetch_count", {32'd0, fetch_count}, 64'd0);
    chk("reset.fault", {63'd0, fault}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      set_in(tbl[i].fe, tbl[i].br, tbl[i].tgt, tbl[i].rdy);
      cycle();
      chk($sformatf("vec%0d.if_valid", i), {63'd0, if_valid}, {63'd0, tbl[i].exp_valid});
      chk($sformatf("vec%0d.if_pc", i), if_pc, tbl[i].exp_pc);
      chk($sformatf("vec%0d.if_instruction", i), {32'd0, if_instruction}, {32'd0, tbl[i].exp_ins});
      chk($sformatf("vec%0d.fault", i), {63'd0, fault}, {63'd0, tbl[i].exp_fault});
      chk($sformatf("vec%0d.fault_cause", i), {62'd0, fault_cause}, {62'd0, tbl[i].exp_cause});
      chk($sformatf("vec%0d.fetch_count", i), {32'd0, fetch_count}, {32'd0, tbl[i].exp_cnt});
      chk($sformatf("vec%0d.inst_addr", i), inst_addr, tbl[i].exp_addr);
    end

    // Stall: hold PC 4 for three cycles.
    do_reset();
    set_in(1'b1, 1'b0, 64'd0, 1'b1);
    cycle();
    cycle();
    chk("stall.pre_if_pc", if_pc, 64'd4);
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall.if_valid", {63'd0, if_valid}, 64'd1);
      chk("stall.if_pc", if_pc, 64'd4);
      chk("stall.if_instruction", {32'd0, if_instruction}, 64'h009A84B3);
      chk("stall.inst_addr", inst_addr, 64'd8);
    end
    id_ready = 1'b1;
    cycle();
    chk("stall.release_if_pc", if_pc, 64'd8);
    chk("stall.release_count", {32'd0, fetch_count}, 64'd2);

    // Redirect while the word at PC 0 is being accepted.
    do_reset();
    set_in(1'b1, 1'b0, 64'd0, 1'b1);
    cycle();
    set_in(1'b1, 1'b1, 64'd12, 1'b1);
    cycle();
    chk("redir.fetch_count", {32'd0, fetch_count}, 64'd1);
    chk("redir.if_valid", {63'd0, if_valid}, 64'd0);
    chk("redir.inst_addr", inst_addr, 64'd12);
    set_in(1'b1, 1'b0, 64'd0, 1'b1);
    cycle();
    chk("redir.if_pc", if_pc, 64'd12);
    chk("redir.if_instruction", {32'd0, if_instruction}, 64'h0E953823);

    // Misaligned redirect, then attempts to escape FAULT.
    do_reset();
    set_in(1'b1, 1'b1, 64'd6, 1'b1);
    cycle();
    chk("misal.fault", {63'd0, fault}, 64'd1);
    chk("misal.fault_cause", {62'd0, fault_cause}, 64'd1);
    chk("misal.if_valid", {63'd0, if_valid}, 64'd0);
    set_in(1'b1, 1'b1, 64'd4, 1'b1);
    cycle();
    set_in(1'b1, 1'b0, 64'd0, 1'b1);
    cycle();
    chk("misal.stuck_inst_addr", inst_addr, 64'd0);
    chk("misal.stuck_if_valid", {63'd0, if_valid}, 64'd0);
    chk("misal.stuck_cause", {62'd0, fault_cause}, 64'd1);
    chk("misal.stuck_count", {32'd0, fetch_count}, 64'd0);

    // Asynchronous reset between edges while a word is held.
    do_reset();
    set_in(1'b1, 1'b0, 64'd0, 1'b1);
    cycle();
    cycle();
    chk("areset.pre_valid", {63'd0, if_valid}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("areset.if_valid", {63'd0, if_valid}, 64'd0);
    chk("areset.if_pc", if_pc, 64'd0);
    chk("areset.if_instruction", {32'd0, if_instruction}, 64'd0);
    chk("areset.inst_addr", inst_addr, 64'd0);
    chk("areset.fetch_count", {32'd0, fetch_count}, 64'd0);
    model_reset();
    reset = 1'b1;
    cycle();
    chk("areset.first_pc", if_pc, 64'd0);
    chk("areset.first_ins", {32'd0, if_instruction}, 64'h0F053483);
    chk("areset.first_count", {32'd0, fetch_count}, 64'd0);

    // fetch_en low drains the slot and freezes the PC; re-enable resumes.
    do_reset();
    set_in(1'b1, 1'b0, 64'd0, 1'b1);
    cycle();
    fetch_en = 1'b0;
    cycle();
    cycle();
    chk("fe0.if_valid", {63'd0, if_valid}, 64'd0);
    chk("fe0.inst_addr", inst_addr, 64'd4);
    fetch_en = 1'b1;
    cycle();
    chk("fe0.resume_pc", if_pc, 64'd4);
    chk("fe0.resume_ins", {32'd0, if_instruction}, 64'h009A84B3);

    // Randomized traffic against the model.
    do_reset();
    begin
      int fault_age;
      fault_age = 0;
      for (int n = 0; n < 400; n++) begin
        int r;
        logic [63:0] t;
        r = $urandom_range(0, 19);
        if (r < 14)       t = 64'($urandom_range(0, 3) * 4);
        else if (r < 16)  t = 64'($urandom_range(0, 3) * 4 + 2);
        else if (r < 18)  t = 64'd16;
        else              t = {$urandom, $urandom};
        set_in($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, t,
               $urandom_range(0, 4) > 1);
        cycle();
        cmp_model($sformatf("rand%0d", n));
        fault_age = m_fault ? fault_age + 1 : 0;
        if (fault_age > 3) begin
          do_reset();
          fault_age = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
